cpu_regfile: RTL and testbench
==============================

Name: cpu_regfile

Overview:
6502 architectural register file: A, X, Y and S (stack pointer), plus the N and Z status flags derived from register loads.
- Sits directly upstream of the 4:1 byte mux that feeds the ALU/internal bus.
- The a/x/y/s outputs drive the mux inputs in0..in3 in that order, so a 2-bit register select means the same register on both sides.
- Also produces the page-1 stack address for push/pull cycles.

Parameters:
SP_RESET, 8'hFD, value loaded into S on reset.
STACK_PAGE, 8'h01, high byte of stack_addr.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
rdy  input  1  1 = advance; 0 = freeze all state (6502 RDY stall)
wr_en  input  1  write wr_data into register selected by wr_sel
wr_sel  input  2  0=A, 1=X, 2=Y, 3=S
wr_data  input  8  value from internal data bus
nz_upd  input  1  with wr_en, update N/Z from wr_data
sp_inc  input  1  S <= S+1 (pull)
sp_dec  input  1  S <= S-1 (push)
a_out  output  8  register A
x_out  output  8  register X
y_out  output  8  register Y
s_out  output  8  register S
stack_addr  output  16  {STACK_PAGE, S}
n_flag  output  1  negative flag
z_flag  output  1  zero flag

Behaviour:
- Reset state: A=X=Y=8'h00, S=SP_RESET, N=0, Z=0, so stack_addr=16'h01FD.
- Reset priority: reset wins over rdy and all other inputs.
- All outputs come straight from registers; no combinational path from inputs to outputs.
- Write latency: a value written at edge k is visible on the outputs after edge k and is readable through the downstream mux in cycle k+1.
- Stall: rdy=0 holds every register and flag; wr_en, sp_inc, sp_dec and nz_upd are ignored that cycle.
- Write (rdy=1, wr_en=1): the register at wr_sel takes wr_data; the other registers hold.
- Flags (rdy=1, wr_en=1, nz_upd=1, wr_sel!=3): N<=wr_data[7], Z<=(wr_data==8'h00).
- Flags on S write: nz_upd is ignored when wr_sel==3 (TXS does not touch flags).
- Flags otherwise: N and Z hold.
- Stack pointer arithmetic: modulo 256.
  - 8'hFF + 1 -> 8'h00.
  - 8'h00 - 1 -> 8'hFF.
  - Stack high byte never changes.
- sp_inc and sp_dec both high: S holds.
- wr_en=1 with wr_sel==3 and sp_inc or sp_dec high: the write wins and the inc/dec is dropped.
- wr_en to A/X/Y together with sp_inc/sp_dec: both take effect in the same edge.
- Reset asserted mid-operation, e.g. between a push's address cycle and its decrement: state returns to reset values at the next edge; no pending operation survives reset.

Decomposition:
- Shared package cpu_pkg holds:
  - register select constants REG_A=2'd0, REG_X=2'd1, REG_Y=2'd2, REG_S=2'd3, shared with the downstream mux select logic;
  - SP_RESET default and STACK_PAGE constant.
- One natural sub-module: stack_ptr. It holds the 8-bit S register with load/inc/dec/hold priority (reset > stall > load > inc/dec) and the stack_addr concatenation.
- A, X, Y and the flags stay inline in cpu_regfile.

Test Plan:
- Reset with rdy=0 and wr_en=1 -> next cycle A=X=Y=00, S=FD, stack_addr=01FD, N=0, Z=0.
- Write 8'h80 to X with nz_upd=1, then 8'h00 to Y with nz_upd=1 -> X=80, N=1, Z=0; then Y=00, N=0, Z=1; A unchanged.
- S=00, sp_dec -> S=FF, stack_addr=01FF; then sp_inc -> S=00. Also sp_inc and sp_dec together -> S holds.
- S=FD, wr_en with wr_sel=3, wr_data=40, nz_upd=1, sp_dec=1 -> S=40; N/Z unchanged; no decrement.
- rdy=0 for 3 cycles with a write to A of 55 and sp_inc -> all outputs frozen; rdy=1 with the same inputs -> A=55, S increments once.
- Reset asserted while sp_dec is held -> S=FD after the edge, and decrements resume only after reset drops.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cpu_pkg                                                     |
// | Brief   : Shared register-select encodings and stack constants for    |
// |           the 6502 register file and the downstream byte mux.         |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
package cpu_pkg;

  // Register selects; the same encoding drives the downstream 4:1 mux
  localparam logic [1:0] REG_A = 2'd0;
  localparam logic [1:0] REG_X = 2'd1;
  localparam logic [1:0] REG_Y = 2'd2;
  localparam logic [1:0] REG_S = 2'd3;

  // Default stack pointer after reset and the fixed stack page
  localparam logic [7:0] SP_RESET_DFLT   = 8'hFD;
  localparam logic [7:0] STACK_PAGE_DFLT = 8'h01;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/stack_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : stack_ptr                                                   |
// | Brief   : 8-bit 6502 stack pointer with load/inc/dec/hold and the     |
// |           page-fixed 16-bit stack address.                            |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module stack_ptr #(
  parameter logic [7:0] SP_RESET   = 8'hFD,
  parameter logic [7:0] STACK_PAGE = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rdy,
  input  logic        i_load,
  input  logic [7:0]  i_load_data,
  input  logic        i_inc,
  input  logic        i_dec,
  output logic [7:0]  o_s,
  output logic [15:0] o_addr
);

  logic [7:0] r_s;

  // Priority: reset > stall > load > inc/dec; inc with dec cancels out
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s <= SP_RESET;
    end else if (i_rdy) begin
      if (i_load) begin
        r_s <= i_load_data;
      end else if (i_inc && !i_dec) begin
        r_s <= r_s + 8'd1;
      end else if (i_dec && !i_inc) begin
        r_s <= r_s - 8'd1;
      end
    end
  end

  assign o_s    = r_s;
  assign o_addr = {STACK_PAGE, r_s};

endmodule : stack_ptr
`default_nettype wire

// File: rtl/cpu_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cpu_regfile                                                 |
// | Brief   : 6502 architectural registers A/X/Y/S with N/Z flags from    |
// |           register loads; all outputs come straight from flops.       |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module cpu_regfile
  import cpu_pkg::*;
#(
  parameter logic [7:0] SP_RESET   = SP_RESET_DFLT,
  parameter logic [7:0] STACK_PAGE = STACK_PAGE_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rdy,
  input  logic        wr_en,
  input  logic [1:0]  wr_sel,
  input  logic [7:0]  wr_data,
  input  logic        nz_upd,
  input  logic        sp_inc,
  input  logic        sp_dec,
  output logic [7:0]  a_out,
  output logic [7:0]  x_out,
  output logic [7:0]  y_out,
  output logic [7:0]  s_out,
  output logic [15:0] stack_addr,
  output logic        n_flag,
  output logic        z_flag
);

  logic [7:0] r_a;
  logic [7:0] r_x;
  logic [7:0] r_y;
  logic       r_n;
  logic       r_z;
  logic       w_s_load;

  // A write to S overrides any concurrent inc/dec of the stack pointer
  assign w_s_load = wr_en && (wr_sel == REG_S);

  stack_ptr #(
    .SP_RESET   (SP_RESET),
    .STACK_PAGE (STACK_PAGE)
  ) u_stack_ptr (
    .clk         (clk),
    .rst         (reset),
    .i_rdy       (rdy),
    .i_load      (w_s_load),
    .i_load_data (wr_data),
    .i_inc       (sp_inc),
    .i_dec       (sp_dec),
    .o_s         (s_out),
    .o_addr      (stack_addr)
  );

  // A/X/Y load and N/Z update; S writes (TXS) never touch the flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a <= 8'h00;
      r_x <= 8'h00;
      r_y <= 8'h00;
      r_n <= 1'b0;
      r_z <= 1'b0;
    end else if (rdy) begin
      if (wr_en) begin
        case (wr_sel)
          REG_A:   r_a <= wr_data;
          REG_X:   r_x <= wr_data;
          REG_Y:   r_y <= wr_data;
          default: ;
        endcase
        if (nz_upd && (wr_sel != REG_S)) begin
          r_n <= wr_data[7];
          r_z <= (wr_data == 8'h00);
        end
      end
    end
  end

  assign a_out  = r_a;
  assign x_out  = r_x;
  assign y_out  = r_y;
  assign n_flag = r_n;
  assign z_flag = r_z;

endmodule : cpu_regfile
`default_nettype wire

// File: tb/tb_cpu_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_cpu_regfile                                              |
// | Brief   : Self-checking bench for cpu_regfile: directed scenarios     |
// |           with literal expectations plus randomized traffic against   |
// |           an array-based reference model checked every cycle.         |
// | Revision: 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module tb_cpu_regfile;

  logic        clk;
  logic        reset;
  logic        rdy;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [7:0]  wr_data;
  logic        nz_upd;
  logic        sp_inc;
  logic        sp_dec;
  logic [7:0]  a_out;
  logic [7:0]  x_out;
  logic [7:0]  y_out;
  logic [7:0]  s_out;
  logic [15:0] stack_addr;
  logic        n_flag;
  logic        z_flag;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  // Reference model: index 0..3 = A, X, Y, S
  logic [7:0] m_r [4];
  logic       m_n;
  logic       m_z;

  cpu_regfile dut (
    .clk        (clk),
    .reset      (reset),
    .rdy        (rdy),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .nz_upd     (nz_upd),
    .sp_inc     (sp_inc),
    .sp_dec     (sp_dec),
    .a_out      (a_out),
    .x_out      (x_out),
    .y_out      (y_out),
    .s_out      (s_out),
    .stack_addr (stack_addr),
    .n_flag     (n_flag),
    .z_flag     (z_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model update straight from the architectural rules
  always @(posedge clk) begin
    if (reset) begin
      m_r[0] <= 8'h00;
      m_r[1] <= 8'h00;
      m_r[2] <= 8'h00;
      m_r[3] <= 8'hFD;
      m_n    <= 1'b0;
      m_z    <= 1'b0;
    end else if (rdy) begin
      if (wr_en) m_r[wr_sel] <= wr_data;
      if (wr_en && nz_upd && wr_sel != 2'd3) begin
        m_n <= wr_data >= 8'h80;
        m_z <= wr_data == 0;
      end
      if (!(wr_en && wr_sel == 2'd3)) begin
        if (sp_inc && !sp_dec) m_r[3] <= 8'((int'(m_r[3]) + 1) % 256);
        if (sp_dec && !sp_inc) m_r[3] <= 8'((int'(m_r[3]) + 255) % 256);
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      chk("model_a", {8'h00, a_out}, {8'h00, m_r[0]});
      chk("model_x", {8'h00, x_out}, {8'h00, m_r[1]});
      chk("model_y", {8'h00, y_out}, {8'h00, m_r[2]});
      chk("model_s", {8'h00, s_out}, {8'h00, m_r[3]});
      chk("model_addr", stack_addr, {8'h01, m_r[3]});
      chk("model_n", {15'h0, n_flag}, {15'h0, m_n});
      chk("model_z", {15'h0, z_flag}, {15'h0, m_z});
    end
  end

  // Apply one cycle of inputs just after a falling edge, return at the next one
  task automatic step(input logic r, input logic rd, input logic we, input logic [1:0] sel,
                      input logic [7:0] d, input logic nz, input logic inc, input logic dec);
    reset = r; rdy = rd; wr_en = we; wr_sel = sel; wr_data = d;
    nz_upd = nz; sp_inc = inc; sp_dec = dec;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; rdy = 1'b0; wr_en = 1'b1; wr_sel = 2'd0; wr_data = 8'hAA;
    nz_upd = 1'b1; sp_inc = 1'b0; sp_dec = 1'b0;
    @(negedge clk);
    // Reset beats rdy=0 and a pending write
    step(1, 0, 1, 2'd0, 8'hAA, 1, 0, 0);
    chk("rst_a", {8'h00, a_out}, 16'h0000);
    chk("rst_x", {8'h00, x_out}, 16'h0000);
    chk("rst_y", {8'h00, y_out}, 16'h0000);
    chk("rst_s", {8'h00, s_out}, 16'h00FD);
    chk("rst_addr", stack_addr, 16'h01FD);
    chk("rst_nz", {14'h0, n_flag, z_flag}, 16'h0000);
    started = 1;

    // Flag updates from X and Y loads
    step(0, 1, 1, 2'd1, 8'h80, 1, 0, 0);
    chk("ldx_x", {8'h00, x_out}, 16'h0080);
    chk("ldx_nz", {14'h0, n_flag, z_flag}, 16'h0002);
    step(0, 1, 1, 2'd2, 8'h00, 1, 0, 0);
    chk("ldy_y", {8'h00, y_out}, 16'h0000);
    chk("ldy_nz", {14'h0, n_flag, z_flag}, 16'h0001);
    chk("ldy_a", {8'h00, a_out}, 16'h0000);

    // Stack pointer wrap in both directions and inc+dec hold
    step(0, 1, 1, 2'd3, 8'h00, 0, 0, 0);
    step(0, 1, 0, 2'd0, 8'h00, 0, 0, 1);
    chk("dec_wrap_s", {8'h00, s_out}, 16'h00FF);
    chk("dec_wrap_addr", stack_addr, 16'h01FF);
    step(0, 1, 0, 2'd0, 8'h00, 0, 1, 0);
    chk("inc_wrap_s", {8'h00, s_out}, 16'h0000);
    step(0, 1, 0, 2'd0, 8'h00, 0, 1, 1);
    chk("incdec_hold", {8'h00, s_out}, 16'h0000);

    // S write wins over dec and leaves flags alone
    step(0, 1, 1, 2'd3, 8'hFD, 0, 0, 0);
    step(0, 1, 1, 2'd3, 8'h40, 1, 0, 1);
    chk("txs_s", {8'h00, s_out}, 16'h0040);
    chk("txs_nz", {14'h0, n_flag, z_flag}, 16'h0001);

    // Stall for three cycles, then release with the same inputs
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 2'd0, 8'h55, 1, 1, 0);
      chk("stall_a", {8'h00, a_out}, 16'h0000);
      chk("stall_s", {8'h00, s_out}, 16'h0040);
    end
    step(0, 1, 1, 2'd0, 8'h55, 1, 1, 0);
    chk("release_a", {8'h00, a_out}, 16'h0055);
    chk("release_s", {8'h00, s_out}, 16'h0041);
    chk("release_nz", {14'h0, n_flag, z_flag}, 16'h0000);

    // Reset while a decrement is held, then decrements resume
    step(1, 1, 0, 2'd0, 8'h00, 0, 0, 1);
    chk("rst_dec_s", {8'h00, s_out}, 16'h00FD);
    chk("rst_dec_a", {8'h00, a_out}, 16'h0000);
    step(0, 1, 0, 2'd0, 8'h00, 0, 0, 1);
    chk("resume_dec_s", {8'h00, s_out}, 16'h00FC);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           2'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_cpu_regfile
`default_nettype wire
